// File: rtl/mips_rtype_pipe.sv
// mips_rtype_pipe: two-stage (ID, EX/WB) R-type MIPS execution core.
// Valid/ready input handshake, output backpressure, EX-to-ID forwarding,
// register preload port, illegal-instruction flag and retired counter.
module mips_rtype_pipe #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic              ld_en,
    input  logic [4:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    output logic [DATA_W-1:0] instr_count
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;

    // Register file
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];

    // ID/EX pipeline register
    logic              ex_valid_q, ex_valid_d;
    logic              ex_legal_q, ex_legal_d;
    logic [5:0]        ex_funct_q, ex_funct_d;
    logic [4:0]        ex_rd_q,    ex_rd_d;
    logic [DATA_W-1:0] ex_a_q,     ex_a_d;
    logic [DATA_W-1:0] ex_b_q,     ex_b_d;

    // Output / commit registers
    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] result_q,      result_d;
    logic [4:0]        out_rd_q,      out_rd_d;
    logic              out_illegal_q, out_illegal_d;
    logic [DATA_W-1:0] count_q,       count_d;

    logic              stall;
    logic              commit;
    logic              ex_wr;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   shamt_sel;

    logic [5:0]        dec_op, dec_funct;
    logic [4:0]        dec_rs, dec_rt, dec_rd, dec_shamt;
    logic              dec_legal, dec_shift;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [31:0]       sh32;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign commit    = ex_valid_q & ~stall;
    // EX result is architecturally visible (forwardable / writable) only for
    // legal instructions targeting a real, non-zero register.
    assign ex_wr     = ex_valid_q & ex_legal_q & (ex_rd_q != 5'd0) &
                       (32'(ex_rd_q) < NUM_REGS);
    assign shamt_sel = ex_b_q[SH_W-1:0];

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;
    assign instr_count = count_q;

    // EX-stage ALU; illegal instructions produce zero
    always_comb begin
        alu_res = '0;
        case (ex_funct_q)
            F_ADD:   alu_res = ex_a_q + ex_b_q;
            F_SUB:   alu_res = ex_a_q - ex_b_q;
            F_AND:   alu_res = ex_a_q & ex_b_q;
            F_OR:    alu_res = ex_a_q | ex_b_q;
            F_XOR:   alu_res = ex_a_q ^ ex_b_q;
            F_NOR:   alu_res = ~(ex_a_q | ex_b_q);
            F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
            F_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (ex_a_q < ex_b_q)};
            F_SLL:   alu_res = ex_a_q << shamt_sel;
            F_SRL:   alu_res = ex_a_q >> shamt_sel;
            F_SRA:   alu_res = $unsigned($signed(ex_a_q) >>> shamt_sel);
            default: alu_res = '0;
        endcase
        if (!ex_legal_q) begin
            alu_res = '0;
        end
    end

    // ID-stage decode, register read with EX forwarding, operand selection
    always_comb begin
        dec_op    = instruction[31:26];
        dec_rs    = instruction[25:21];
        dec_rt    = instruction[20:16];
        dec_rd    = instruction[15:11];
        dec_shamt = instruction[10:6];
        dec_funct = instruction[5:0];
        dec_shift = ~dec_funct[5];

        dec_legal = 1'b0;
        if (dec_op == 6'd0) begin
            case (dec_funct)
                F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
                F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: dec_legal = 1'b1;
                default:                            dec_legal = 1'b0;
            endcase
        end

        rs_val = '0;
        rt_val = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (32'(dec_rs) == i) rs_val = rf_q[i];
            if (32'(dec_rt) == i) rt_val = rf_q[i];
        end
        if (ex_wr && (ex_rd_q == dec_rs)) rs_val = alu_res;
        if (ex_wr && (ex_rd_q == dec_rt)) rt_val = alu_res;

        sh32 = 32'(dec_shamt) % DATA_W;
    end

    // ID/EX register next state: load on accept, hold while stalled
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_legal_d = ex_legal_q;
        ex_funct_d = ex_funct_q;
        ex_rd_d    = ex_rd_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        if (!stall) begin
            ex_valid_d = in_valid;
            if (in_valid) begin
                ex_legal_d = dec_legal;
                ex_funct_d = dec_funct;
                ex_rd_d    = dec_rd;
                ex_a_d     = dec_shift ? rt_val : rs_val;
                ex_b_d     = dec_shift ? DATA_W'(sh32) : rt_val;
            end
        end
    end

    // Output registers and retired counter: update on commit, hold on stall
    always_comb begin
        out_valid_d   = stall ? out_valid_q : ex_valid_q;
        result_d      = result_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        count_d       = count_q;
        if (commit) begin
            result_d      = alu_res;
            out_rd_d      = ex_rd_q;
            out_illegal_d = ~ex_legal_q;
            count_d       = count_q + DATA_W'(1);
        end
    end

    // Register file next state: preload first, pipeline write takes priority
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (ld_en && (32'(ld_addr) == i)) rf_d[i] = ld_data;
            if (commit && ex_wr && (32'(ex_rd_q) == i)) rf_d[i] = alu_res;
        end
        rf_d[0] = '0;
    end

    // Register file state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Pipeline and output state
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_legal_q    <= 1'b0;
            ex_funct_q    <= '0;
            ex_rd_q       <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
            count_q       <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_legal_q    <= ex_legal_d;
            ex_funct_q    <= ex_funct_d;
            ex_rd_q       <= ex_rd_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
            count_q       <= count_d;
        end
    end

endmodule
